regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the register file's single write port among several write-back sources (ALU, load unit, CSR unit) using round-robin arbitration. Drives a registered write stage into the register file. Keeps a per-register busy scoreboard so decode can detect read-after-write hazards on the two read ports. Sits between the execution units and the register file; decode drives its issue and check inputs.

## Interface
Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8)
- REG_FILE_SIZE, 32, number of architectural registers

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester write-back request
- req_rd  in  NUM_REQ x 5  per-requester destination register
- req_data  in  NUM_REQ x 32  per-requester write data
- req_ready  out  NUM_REQ  one-hot grant; transfer occurs when valid & ready
- issue_valid  in  1  decode issues an instruction that will write issue_rd
- issue_rd  in  5  destination of the issued instruction
- chk_rs0, chk_rs1  in  5 each  source registers under hazard check
- hazard  out  1  a checked source is pending
- wr_en  out  1  register file write enable
- wr_reg_num  out  5  register file write index
- wr_data  out  32  register file write data
- busy_vec  out  REG_FILE_SIZE  scoreboard state
- sb_err  out  1  sticky: a write-back was granted to a non-busy register

## Operation
- Arbiter: round-robin with a priority pointer ptr (0..NUM_REQ-1). Grant goes to the first valid requester at or after ptr, with wrap-around. req_ready is combinational from req_valid and ptr; at most one bit is set. No grant when no request is valid.
- After a grant, ptr = granted index + 1 mod NUM_REQ. ptr is unchanged when nothing is granted.
- Write stage: on a grant, the next edge loads wr_reg_num/wr_data from the winner. wr_en = 1 for exactly one cycle unless rd == 0.
- A grant with rd == 0 is accepted (ready asserted) but wr_en stays 0. busy_vec and sb_err are unaffected.
- Scoreboard set: issue_valid & issue_rd != 0 sets busy[issue_rd] at the edge.
- Scoreboard clear: busy[wr_reg_num] clears at the edge where wr_en = 1, i.e., the same edge the register file writes.
- Simultaneous set and clear of the same register: set wins, because a new producer supersedes the old one.
- hazard = (chk_rs0 != 0 & busy[chk_rs0]) | (chk_rs1 != 0 & busy[chk_rs1]), combinational.
- sb_err sets when a grant with rd != 0 targets a register whose busy bit is 0 and which is not being set that cycle. It clears only on reset.
- busy[0] is constant 0.

## Timing
- Reset values: ptr = 0, wr_en = 0, wr_reg_num = 0, wr_data = 0, busy_vec = 0, sb_err = 0. req_ready follows req_valid with ptr = 0.
- Reset asserted mid-operation: all state clears immediately. An in-flight write is dropped and wr_en deasserts asynchronously.
- Latency: grant in cycle N → wr_en in N+1 → register file updated and busy cleared at the end of N+1 → hazard drops in N+2 (N+1 with bypass).
- Throughput: one write-back per cycle; back-to-back grants are allowed.
- A requester must hold valid, rd and data stable until it sees ready.

## Configuration
- REGFILE_WB_BYPASS_EN defined: adds outputs fwd_valid0/1 (1 bit each) and fwd_data0/1 (32 bits each).
  - When wr_en = 1, wr_reg_num != 0 and chk_rsX == wr_reg_num, fwd_validX = 1 and fwd_dataX = wr_data.
  - That source's contribution to hazard is masked in the same cycle.
- REGFILE_WB_BYPASS_EN undefined: the fwd_* ports are absent, and hazard holds until busy clears.

## Structure
- Shared package regfile_pkg:
  - REG_IDX_W = 5, XLEN = 32, REG_ZERO = 5'd0
  - typedef wb_req_t {rd, data}
- Sub-module rr_arbiter holds the round-robin grant logic and ptr. It is parameterised by NUM_REQ and outputs a one-hot grant plus the encoded index.
- The scoreboard and write stage live in the top module.

## Test plan
- Reset, then all three requesters valid with rd 1, 2, 3 → grants in order 0, 1, 2, 0; wr_en pulses each cycle with rd 1, 2, 3.
- Issue rd = 5, check rs0 = 5 → hazard = 1. Requester 1 writes rd 5, data 0xDEADBEEF → wr_en next cycle; hazard = 0 the cycle after (same cycle with bypass, fwd_data0 = 0xDEADBEEF).
- Requester 0 writes rd = 0, data 0x1234 → ready = 1, wr_en stays 0, busy_vec unchanged, sb_err = 0.
- Issue rd = 7 in the same cycle that wr_en clears rd 7 → busy[7] remains 1.
- Grant a write to rd 9 that was never issued → sb_err = 1, and it stays set until rst.
- Assert rst while wr_en = 1 with busy_vec = 0x0000_00A0 → wr_en, busy_vec and ptr read 0 immediately; after release the first grant goes to requester 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after ptr,
// then moves ptr just past the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!grant_valid && req_valid[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter, registered write stage and busy scoreboard for the
// register file. Define REGFILE_WB_BYPASS_EN to add write-stage forwarding.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int REG_FILE_SIZE = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  // A write-back transfers on a cycle where req_valid[i] & req_ready[i];
  // the requester holds valid, rd and data stable until then.
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][REG_IDX_W-1:0] req_rd,
  input  logic [NUM_REQ-1:0][XLEN-1:0]      req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              issue_valid,
  input  logic [REG_IDX_W-1:0]              issue_rd,
  input  logic [REG_IDX_W-1:0]              chk_rs0,
  input  logic [REG_IDX_W-1:0]              chk_rs1,
  output logic                              hazard,
  output logic                              wr_en,
  output logic [REG_IDX_W-1:0]              wr_reg_num,
  output logic [XLEN-1:0]                   wr_data,
  output logic [REG_FILE_SIZE-1:0]          busy_vec,
`ifdef REGFILE_WB_BYPASS_EN
  output logic                              fwd_valid0,
  output logic                              fwd_valid1,
  output logic [XLEN-1:0]                   fwd_data0,
  output logic [XLEN-1:0]                   fwd_data1,
`endif
  output logic                              sb_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       grant;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_valid;
  wb_req_t                  win;
  logic [REG_FILE_SIZE-1:0] busy_q, busy_next, set_mask, clr_mask, win_mask;
  logic                     win_busy, win_set, sb_err_set;
  logic                     rs0_busy, rs1_busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant;
  assign win.rd    = req_rd[grant_idx];
  assign win.data  = req_data[grant_idx];

  // rd == 0 is accepted and consumed but never reaches the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_reg_num <= REG_ZERO;
      wr_data    <= '0;
    end else begin
      wr_en <= grant_valid && (win.rd != REG_ZERO);
      if (grant_valid) begin
        wr_reg_num <= win.rd;
        wr_data    <= win.data;
      end
    end
  end

  // Set is applied after clear so a fresh producer supersedes the retiring one.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && (issue_rd != REG_ZERO))
      set_mask = REG_FILE_SIZE'(1) << issue_rd;
    if (wr_en)
      clr_mask = REG_FILE_SIZE'(1) << wr_reg_num;
    busy_next    = (busy_q & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  assign win_mask   = REG_FILE_SIZE'(1) << win.rd;
  assign win_busy   = |(busy_q & win_mask);
  assign win_set    = |(set_mask & win_mask);
  assign sb_err_set = grant_valid && (win.rd != REG_ZERO) && !win_busy && !win_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      sb_err <= 1'b0;
    end else begin
      busy_q <= busy_next;
      if (sb_err_set)
        sb_err <= 1'b1;
    end
  end

  assign busy_vec = busy_q;
  assign rs0_busy = (chk_rs0 != REG_ZERO) && |(busy_q & (REG_FILE_SIZE'(1) << chk_rs0));
  assign rs1_busy = (chk_rs1 != REG_ZERO) && |(busy_q & (REG_FILE_SIZE'(1) << chk_rs1));

`ifdef REGFILE_WB_BYPASS_EN
  assign fwd_valid0 = wr_en && (wr_reg_num != REG_ZERO) && (chk_rs0 == wr_reg_num);
  assign fwd_valid1 = wr_en && (wr_reg_num != REG_ZERO) && (chk_rs1 == wr_reg_num);
  assign fwd_data0  = wr_data;
  assign fwd_data1  = wr_data;
  assign hazard     = (rs0_busy && !fwd_valid0) || (rs1_busy && !fwd_valid1);
`else
  assign hazard     = rs0_busy || rs1_busy;
`endif

endmodule
